// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register file.
package axi_lite_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_COLLECT,
        W_COMMIT,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    function automatic logic [DATA_W-1:0] apply_wstrb(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] data,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave holding NUM_REGS byte-writable 32-bit registers, exported in parallel.
// state     | meaning
// W_COLLECT | accepting AW and W in any order, each ready drops after its own handshake
// W_COMMIT  | both captured; write register, raise bvalid
// W_RESP    | holding B response until bready
// R_IDLE    | arready high, waiting for AR
// R_DATA    | holding R response until rready
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [31:0]                awaddr,
    input  logic [2:0]                 awprot,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [STRB_W-1:0]          wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [31:0]                araddr,
    input  logic [2:0]                 arprot,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [NUM_REGS*DATA_W-1:0] regs_q
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    function automatic logic in_range(input logic [31:0] addr);
        return addr[31:2] < 30'(NUM_REGS);
    endfunction

    logic unused_bits;
    assign unused_bits = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

    logic [DATA_W-1:0] regs [NUM_REGS];

    w_state_t          w_state_q, w_state_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic              aw_ok_q, aw_ok_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              awready_q, awready_d, wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    resp_t             bresp_q, bresp_d;
    logic              do_write;

    r_state_t          r_state_q, r_state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    resp_t             rresp_q, rresp_d;

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_idx_d  = aw_idx_q;
        aw_ok_d   = aw_ok_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        do_write  = 1'b0;
        unique case (w_state_q)
            W_COLLECT: begin
                if (awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = awaddr[2 +: IDX_W];
                    aw_ok_d   = in_range(awaddr);
                end
                if (wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                end
                awready_d = !aw_held_d;
                wready_d  = !w_held_d;
                if (aw_held_d && w_held_d) w_state_d = W_COMMIT;
            end
            W_COMMIT: begin
                do_write  = aw_ok_q;
                bvalid_d  = 1'b1;
                bresp_d   = aw_ok_q ? OKAY : SLVERR;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_COLLECT;
                end
            end
            default: w_state_d = W_COLLECT;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_COLLECT;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            aw_ok_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_idx_q  <= aw_idx_d;
            aw_ok_q   <= aw_ok_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (do_write) begin
            regs[aw_idx_q] <= apply_wstrb(regs[aw_idx_q], wdata_q, wstrb_q);
        end
    end

    // Reads sample the array before any same-edge commit, so a collision returns the old value.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    rvalid_d  = 1'b1;
                    rresp_d   = in_range(araddr) ? OKAY : SLVERR;
                    rdata_d   = in_range(araddr) ? regs[araddr[2 +: IDX_W]] : '0;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_q[DATA_W*i +: DATA_W] = regs[i];
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: cycle-level protocol model plus literal spot checks.
module tb_axi_lite_regfile;

    localparam int NREGS = 16;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [31:0]       awaddr = '0;
    logic [2:0]        awprot = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b1;
    logic [31:0]       araddr = '0;
    logic [2:0]        arprot = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b1;
    logic [NREGS*32-1:0] regs_q;

    int total = 0;
    int bad = 0;

    axi_lite_regfile #(.NUM_REGS(NREGS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_q(regs_q)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mregs [NREGS];
    logic        m_awready, m_wready, m_arready, m_bvalid, m_rvalid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;
    logic        m_have_aw, m_have_w, m_commit;
    logic [31:0] m_awaddr, m_wdata;
    logic [3:0]  m_wstrb;

    function automatic bit addr_ok(input logic [31:0] a);
        return (a >> 2) < NREGS;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NREGS; i++) mregs[i] = '0;
            m_awready = 0; m_wready = 0; m_arready = 0;
            m_bvalid = 0; m_rvalid = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0;
            m_have_aw = 0; m_have_w = 0; m_commit = 0;
            m_awaddr = 0; m_wdata = 0; m_wstrb = 0;
        end else begin
            bit aw_hs, w_hs, ar_hs;
            aw_hs = awvalid && m_awready;
            w_hs  = wvalid && m_wready;
            ar_hs = arvalid && m_arready;
            // read side first: it must observe contents from before this edge's write
            if (m_rvalid) begin
                if (rready) begin m_rvalid = 0; m_arready = 1; end
            end else if (ar_hs) begin
                m_rvalid  = 1;
                m_arready = 0;
                m_rresp   = addr_ok(araddr) ? 2'b00 : 2'b10;
                m_rdata   = addr_ok(araddr) ? mregs[araddr >> 2] : 32'h0;
            end else begin
                m_arready = 1;
            end
            if (m_commit) begin
                if (addr_ok(m_awaddr)) begin
                    for (int b = 0; b < 4; b++)
                        if (m_wstrb[b]) mregs[m_awaddr >> 2][8*b +: 8] = m_wdata[8*b +: 8];
                end
                m_bresp = addr_ok(m_awaddr) ? 2'b00 : 2'b10;
                m_bvalid = 1; m_commit = 0; m_have_aw = 0; m_have_w = 0;
            end else if (m_bvalid) begin
                if (bready) begin m_bvalid = 0; m_awready = 1; m_wready = 1; end
            end else begin
                if (aw_hs) begin m_have_aw = 1; m_awaddr = awaddr; end
                if (w_hs) begin m_have_w = 1; m_wdata = wdata; m_wstrb = wstrb; end
                m_awready = !m_have_aw;
                m_wready  = !m_have_w;
                if (m_have_aw && m_have_w) m_commit = 1;
            end
        end
    end

    always @(posedge aclk) begin
        #2;
        chk("awready", {31'b0, awready}, {31'b0, m_awready});
        chk("wready",  {31'b0, wready},  {31'b0, m_wready});
        chk("arready", {31'b0, arready}, {31'b0, m_arready});
        chk("bvalid",  {31'b0, bvalid},  {31'b0, m_bvalid});
        chk("bresp",   {30'b0, bresp},   {30'b0, m_bresp});
        chk("rvalid",  {31'b0, rvalid},  {31'b0, m_rvalid});
        chk("rresp",   {30'b0, rresp},   {30'b0, m_rresp});
        chk("rdata",   rdata, m_rdata);
        for (int i = 0; i < NREGS; i++)
            chk($sformatf("regs_q[%0d]", i), regs_q[32*i +: 32], mregs[i]);
    end

    // ---------------- drivers ----------------
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int w_lead, output logic [1:0] resp, output int lat);
        int  cyc, aw_at, w_at;
        bit  aw_done, w_done, aw_go, w_go;
        aw_at = (w_lead > 0) ? w_lead : 0;
        w_at  = (w_lead < 0) ? -w_lead : 0;
        aw_done = 0; w_done = 0; cyc = 0;
        @(negedge aclk);
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid = !aw_done && cyc >= aw_at;
            wvalid  = !w_done && cyc >= w_at;
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(negedge aclk);
            cyc++;
            if (aw_go) aw_done = 1;
            if (w_go) w_done = 1;
        end
        awvalid = 0; wvalid = 0;
        chk("write_handshake_timeout", {31'b0, aw_done && w_done}, 32'd1);
        lat = 0;
        while (!bvalid && lat < 50) begin @(negedge aclk); lat++; end
        chk("bvalid_timeout", {31'b0, bvalid}, 32'd1);
        resp = bresp;
        if (bready) @(negedge aclk);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int  cyc;
        bit  go;
        cyc = 0; go = 0;
        @(negedge aclk);
        araddr = a;
        arvalid = 1;
        while (!go && cyc < 50) begin
            go = arready;
            @(negedge aclk);
            cyc++;
        end
        arvalid = 0;
        chk("read_handshake_timeout", {31'b0, go}, 32'd1);
        cyc = 0;
        while (!rvalid && cyc < 50) begin @(negedge aclk); cyc++; end
        chk("rvalid_timeout", {31'b0, rvalid}, 32'd1);
        d = rdata;
        resp = rresp;
        if (rready) @(negedge aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;

        repeat (3) @(negedge aclk);
        chk("reset_awready", {31'b0, awready}, 32'd0);
        chk("reset_arready", {31'b0, arready}, 32'd0);
        aresetn = 1;
        @(negedge aclk);
        chk("post_reset_awready", {31'b0, awready}, 32'd1);
        chk("post_reset_wready",  {31'b0, wready},  32'd1);
        chk("post_reset_arready", {31'b0, arready}, 32'd1);

        axi_read(32'h0, d, r);
        chk("read0_data", d, 32'h0);
        chk("read0_resp", {30'b0, r}, 32'd0);

        axi_write(32'h08, 32'hDEADBEEF, 4'hF, 3, r, lat);
        chk("full_write_resp", {30'b0, r}, 32'd0);
        chk("full_write_latency", lat, 32'd1);
        chk("full_write_regs_q", regs_q[95:64], 32'hDEADBEEF);
        axi_read(32'h08, d, r);
        chk("full_write_readback", d, 32'hDEADBEEF);

        axi_write(32'h08, 32'h11223344, 4'h5, 0, r, lat);
        chk("strb_regs_q", regs_q[95:64], 32'hDE22BE44);
        axi_read(32'h0B, d, r);
        chk("strb_readback_lowbits_ignored", d, 32'hDE22BE44);

        axi_write(32'h08, 32'hFFFFFFFF, 4'h0, -2, r, lat);
        chk("zero_strb_resp", {30'b0, r}, 32'd0);
        chk("zero_strb_regs_q", regs_q[95:64], 32'hDE22BE44);

        axi_write(32'h40, 32'h55555555, 4'hF, -2, r, lat);
        chk("oor_write_resp", {30'b0, r}, 32'd2);
        chk("oor_write_no_change", regs_q[95:64], 32'hDE22BE44);
        axi_read(32'h40, d, r);
        chk("oor_read_data", d, 32'h0);
        chk("oor_read_resp", {30'b0, r}, 32'd2);

        for (int i = 0; i < 4; i++) axi_write(32'(i * 4 + 16), 32'hA0 + 32'(i), 4'hF, 0, r, lat);
        axi_write(32'h0C, 32'hAAAA5555, 4'hF, 0, r, lat);

        // same-edge AR and commit on 0x0C, both responses backpressured
        @(negedge aclk);
        bready = 0; rready = 0;
        awaddr = 32'h0C; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge aclk);
        awvalid = 0; wvalid = 0;
        araddr = 32'h0C; arvalid = 1;
        @(negedge aclk);
        arvalid = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk("bp_bvalid", {31'b0, bvalid}, 32'd1);
            chk("bp_rvalid", {31'b0, rvalid}, 32'd1);
            chk("bp_collision_rdata", rdata, 32'hAAAA5555);
            chk("bp_awready", {31'b0, awready}, 32'd0);
            chk("bp_arready", {31'b0, arready}, 32'd0);
        end
        bready = 1; rready = 1;
        @(negedge aclk);
        chk("bp_release_bvalid", {31'b0, bvalid}, 32'd0);
        chk("bp_release_rvalid", {31'b0, rvalid}, 32'd0);
        axi_read(32'h0C, d, r);
        chk("collision_new_value", d, 32'h12345678);

        // reset after AW captured, before W
        @(negedge aclk);
        awaddr = 32'h04; awvalid = 1;
        @(negedge aclk);
        awvalid = 0;
        #1 aresetn = 0;
        #1;
        chk("midreset_regs_zero", {31'b0, |regs_q}, 32'd0);
        chk("midreset_bvalid", {31'b0, bvalid}, 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
        axi_write(32'h04, 32'hCAFEF00D, 4'hF, 1, r, lat);
        chk("after_reset_resp", {30'b0, r}, 32'd0);
        axi_read(32'h04, d, r);
        chk("after_reset_readback", d, 32'hCAFEF00D);
        chk("after_reset_other_reg", regs_q[95:64], 32'h0);

        repeat (3) @(negedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
